// File: rtl/ect_dds_pkg.sv
// ect_dds_pkg
// Shared definitions for the ECT excitation sweep controller:
//   - sweep FSM state encoding
//   - NCO control word widths
//   - reset-default frequency words for the sweep table (10 MHz NCO clock)
// No ports; imported by dds_freq_table and dds_sweep_ctrl.
package ect_dds_pkg;

  localparam int PHASE_INC_W = 32;
  localparam int PHASE_MOD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    DWELL,
    NEXT
  } sweepState_t;

  // 100 kHz, 200 kHz, 500 kHz, 1 MHz at a 10 MHz NCO clock. Entries past
  // the fourth power up as 0 (silent) until the host programs them.
  function automatic logic [PHASE_INC_W-1:0] defaultFreqWord(input int idx);
    case (idx)
      0:       return 32'd42949673;
      1:       return 32'd85899346;
      2:       return 32'd214748365;
      3:       return 32'd429496730;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/dds_freq_table.sv
// dds_freq_table
// NUM_PTS x 32-bit register file holding the sweep frequency words.
// Loaded with the package defaults on reset, one synchronous write port,
// asynchronous read so the controller sees the word for PointIdx directly.
// Ports:
//   Clk     in   system clock
//   Rst     in   synchronous reset, active-high (reloads defaults)
//   We      in   write strobe (already qualified by the controller)
//   WrAddr  in   IDX_W  write index
//   WrData  in   32     frequency word
//   RdAddr  in   IDX_W  read index
//   RdData  out  32     frequency word at RdAddr
module dds_freq_table
  import ect_dds_pkg::*;
#(
  parameter int NUM_PTS = 4,
  parameter int IDX_W   = 2
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   We,
  input  logic [IDX_W-1:0]       WrAddr,
  input  logic [PHASE_INC_W-1:0] WrData,
  input  logic [IDX_W-1:0]       RdAddr,
  output logic [PHASE_INC_W-1:0] RdData
);

  logic [PHASE_INC_W-1:0] mem [NUM_PTS];

  // NOTE: this table is reset like ordinary flops because its defaults must
  // be usable straight out of reset; a real RAM array would not be reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < NUM_PTS; i++) begin
        mem[i] <= defaultFreqWord(i);
      end
    end else if (We && (int'(WrAddr) < NUM_PTS)) begin
      mem[WrAddr] <= WrData;
    end
  end

  assign RdData = mem[RdAddr];

endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl
// Steps the ECT excitation NCO through the frequency table one point at a
// time: LOAD (update NCO) -> SETTLE (SETTLE_CYC) -> DWELL (Settled window)
// -> NEXT. Optional wrap for continuous sweeps, Abort to stop at any time.
// Optional feature macro DDS_PHASE_STEP_EN: adds the PhaseStep port and
// advances PhaseMod by PhaseStep at every step to a higher table index;
// without it PhaseMod stays 0.
// Ports:
//   Clk, Rst      clock, synchronous active-high reset
//   Start         begin sweep (ignored while Busy)
//   Abort         stop sweep (wins over Start)
//   Continuous    wrap to point 0 after the last point
//   DwellCycles   Settled window length, latched at Start (0 treated as 1)
//   PhaseStep     per-point phase increment (DDS_PHASE_STEP_EN only)
//   CfgWe/CfgAddr/CfgData  table write port, honoured only in IDLE
//   PhaseInc, FreqMod, PhaseMod, NcoUpdate  NCO control
//   Settled, PointIdx, Busy, Done           status
module dds_sweep_ctrl
  import ect_dds_pkg::*;
#(
  parameter  int NUM_PTS    = 4,
  parameter  int SETTLE_CYC = 8,
  parameter  int DWELL_W    = 16,
  localparam int IDX_W      = $clog2(NUM_PTS)
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Start,
  input  logic                   Abort,
  input  logic                   Continuous,
  input  logic [DWELL_W-1:0]     DwellCycles,
`ifdef DDS_PHASE_STEP_EN
  input  logic [PHASE_MOD_W-1:0] PhaseStep,
`endif
  input  logic                   CfgWe,
  input  logic [IDX_W-1:0]       CfgAddr,
  input  logic [PHASE_INC_W-1:0] CfgData,
  output logic [PHASE_INC_W-1:0] PhaseInc,
  output logic [PHASE_INC_W-1:0] FreqMod,
  output logic [PHASE_MOD_W-1:0] PhaseMod,
  output logic                   NcoUpdate,
  output logic                   Settled,
  output logic [IDX_W-1:0]       PointIdx,
  output logic                   Busy,
  output logic                   Done
);

  localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W    = (DWELL_W > SETTLE_W) ? DWELL_W : SETTLE_W;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_PTS - 1);

  sweepState_t            state, stateNext;
  logic [CNT_W-1:0]       cnt, cntNext;
  logic [DWELL_W-1:0]     dwellLat, dwellLatNext;
  logic [IDX_W-1:0]       idxNext;
  logic [PHASE_INC_W-1:0] phaseIncNext;
  logic [PHASE_MOD_W-1:0] phaseModNext;
  logic [PHASE_MOD_W-1:0] phaseStepEff;
  logic                   ncoUpdateNext;
  logic                   doneNext;
  logic [PHASE_INC_W-1:0] tableWord;

`ifdef DDS_PHASE_STEP_EN
  assign phaseStepEff = PhaseStep;
`else
  // With a zero step PhaseMod can only ever be reloaded with 0.
  assign phaseStepEff = '0;
`endif

  assign FreqMod = '0;

  // The table is frozen during a sweep: writes outside IDLE are dropped.
  dds_freq_table #(
    .NUM_PTS(NUM_PTS),
    .IDX_W  (IDX_W)
  ) uFreqTable (
    .Clk   (Clk),
    .Rst   (Rst),
    .We    (CfgWe && (state == IDLE)),
    .WrAddr(CfgAddr),
    .WrData(CfgData),
    .RdAddr(PointIdx),
    .RdData(tableWord)
  );

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    stateNext     = state;
    cntNext       = cnt;
    dwellLatNext  = dwellLat;
    idxNext       = PointIdx;
    phaseIncNext  = PhaseInc;
    phaseModNext  = PhaseMod;
    ncoUpdateNext = 1'b0;
    doneNext      = 1'b0;

    if (Abort) begin
      // NCO words hold; only the FSM and status flags drop.
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            stateNext    = LOAD;
            idxNext      = '0;
            phaseModNext = '0;
            dwellLatNext = (DwellCycles == '0) ? DWELL_W'(1) : DwellCycles;
          end
        end
        LOAD: begin
          stateNext     = SETTLE;
          cntNext       = SETTLE_LOAD;
          phaseIncNext  = tableWord;
          ncoUpdateNext = 1'b1;
        end
        SETTLE: begin
          if (cnt == '0) begin
            stateNext = DWELL;
            cntNext   = CNT_W'(dwellLat) - CNT_W'(1);
          end else begin
            cntNext = cnt - CNT_W'(1);
          end
        end
        DWELL: begin
          if (cnt == '0) begin
            stateNext = NEXT;
          end else begin
            cntNext = cnt - CNT_W'(1);
          end
        end
        NEXT: begin
          if (PointIdx != LAST_IDX) begin
            stateNext    = LOAD;
            idxNext      = PointIdx + IDX_W'(1);
            phaseModNext = PhaseMod + phaseStepEff;
          end else if (Continuous) begin
            stateNext    = LOAD;
            idxNext      = '0;
            phaseModNext = '0;
          end else begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments only in clocked blocks, so every flop
  // samples the pre-edge value regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dwellLat  <= '0;
      PointIdx  <= '0;
      PhaseInc  <= '0;
      PhaseMod  <= '0;
      NcoUpdate <= 1'b0;
      Settled   <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      dwellLat  <= dwellLatNext;
      PointIdx  <= idxNext;
      PhaseInc  <= phaseIncNext;
      PhaseMod  <= phaseModNext;
      NcoUpdate <= ncoUpdateNext;
      // Status flags follow the state being entered so they are registered
      // yet line up exactly with the state they describe.
      Settled   <= (stateNext == DWELL);
      Busy      <= (stateNext != IDLE);
      Done      <= doneNext;
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl
// Self-checking bench for dds_sweep_ctrl. Expected outputs come from a
// timeline model: a sweep started in cycle 0 occupies points of length
// P = SETTLE_CYC + dwell + 2, and within point k at offset o the outputs
// follow from o alone (o=0 load, o=1 update strobe, o in
// [SETTLE_CYC+1, SETTLE_CYC+dwell] settled window, last offset next-step).
// Works with or without DDS_PHASE_STEP_EN.
module tb_dds_sweep_ctrl;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int DW = 16;
  localparam int IW = 2;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic          Abort;
  logic          Continuous;
  logic [DW-1:0] DwellCycles;
  logic          CfgWe;
  logic [IW-1:0] CfgAddr;
  logic [31:0]   CfgData;
  logic [31:0]   PhaseInc;
  logic [31:0]   FreqMod;
  logic [15:0]   PhaseMod;
  logic          NcoUpdate;
  logic          Settled;
  logic [IW-1:0] PointIdx;
  logic          Busy;
  logic          Done;

`ifdef DDS_PHASE_STEP_EN
  logic [15:0] PhaseStep;
  localparam bit PHASE_STEP_EN = 1'b1;
`else
  localparam bit PHASE_STEP_EN = 1'b0;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] tbl [N];
  logic [31:0] lastPI;
  logic [15:0] lastPM;
  logic [15:0] stepModel;

  always #5 Clk = ~Clk;

  dds_sweep_ctrl #(
    .NUM_PTS   (N),
    .SETTLE_CYC(S),
    .DWELL_W   (DW)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Abort      (Abort),
    .Continuous (Continuous),
    .DwellCycles(DwellCycles),
`ifdef DDS_PHASE_STEP_EN
    .PhaseStep  (PhaseStep),
`endif
    .CfgWe      (CfgWe),
    .CfgAddr    (CfgAddr),
    .CfgData    (CfgData),
    .PhaseInc   (PhaseInc),
    .FreqMod    (FreqMod),
    .PhaseMod   (PhaseMod),
    .NcoUpdate  (NcoUpdate),
    .Settled    (Settled),
    .PointIdx   (PointIdx),
    .Busy       (Busy),
    .Done       (Done)
  );

  task automatic check(input string tag, input int cyc, input logic [31:0] observed,
                       input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic resetModel();
    tbl[0] = 32'd42949673;
    tbl[1] = 32'd85899346;
    tbl[2] = 32'd214748365;
    tbl[3] = 32'd429496730;
    lastPI = '0;
    lastPM = '0;
  endtask

  task automatic setStep(input logic [15:0] s);
    stepModel = s;
`ifdef DDS_PHASE_STEP_EN
    PhaseStep = s;
`endif
  endtask

  task automatic idleInputs();
    Start      = 1'b0;
    Abort      = 1'b0;
    Continuous = 1'b0;
    CfgWe      = 1'b0;
  endtask

  // Host table write in IDLE; the model table follows.
  task automatic cfgWrite(input logic [IW-1:0] addr, input logic [31:0] data);
    @(negedge Clk);
    CfgWe   = 1'b1;
    CfgAddr = addr;
    CfgData = data;
    tbl[addr] = data;
    @(negedge Clk);
    CfgWe = 1'b0;
  endtask

  // One sweep of nPts points (a multiple of N unless aborted). Start is
  // driven in cycle 0; abortAt>0 raises Abort in that cycle; glitchAt>0
  // pulses Start again while busy; busyWrites fires random table writes
  // that must be dropped.
  task automatic runSweep(input int dwellIn, input int nPts, input int abortAt,
                          input int glitchAt, input bit busyWrites);
    int d, p, total, lastC, k, o, eIdx;
    logic [31:0] ePI;
    logic [15:0] ePM;
    logic eBusy, eSet, eUpd, eDone;
    d     = (dwellIn == 0) ? 1 : dwellIn;
    p     = S + d + 2;
    total = nPts * p;
    lastC = (abortAt > 0) ? abortAt + 3 : total + 2;
    ePI   = lastPI;
    ePM   = lastPM;
    eIdx  = 0;
    for (int c = 0; c <= lastC; c++) begin
      @(negedge Clk);
      if (c >= 1) begin
        eBusy = 1'b0;
        eSet  = 1'b0;
        eUpd  = 1'b0;
        eDone = 1'b0;
        if (abortAt > 0 && c > abortAt) begin
          eIdx = -1;
        end else if (c <= total) begin
          k     = (c - 1) / p;
          o     = (c - 1) % p;
          eBusy = 1'b1;
          eIdx  = k % N;
          eUpd  = (o == 1);
          eSet  = (o >= S + 1) && (o <= S + d);
          if (o >= 1) ePI = tbl[k % N];
          else if (k > 0) ePI = tbl[(k - 1) % N];
          ePM = PHASE_STEP_EN ? 16'((k % N) * int'(stepModel)) : 16'h0;
        end else begin
          eDone = (c == total + 1);
        end
        check("Busy", c, 32'(Busy), 32'(eBusy));
        check("Settled", c, 32'(Settled), 32'(eSet));
        check("NcoUpdate", c, 32'(NcoUpdate), 32'(eUpd));
        check("Done", c, 32'(Done), 32'(eDone));
        check("PhaseInc", c, PhaseInc, ePI);
        check("PhaseMod", c, 32'(PhaseMod), 32'(ePM));
        check("FreqMod", c, FreqMod, 32'h0);
        if (eIdx >= 0) check("PointIdx", c, 32'(PointIdx), 32'(eIdx));
      end
      Start       = (c == 0) || (c == glitchAt);
      Abort       = (abortAt > 0) && (c == abortAt);
      DwellCycles = (c == 0) ? DW'(dwellIn) : DW'($urandom);
      if (c >= 1 && c <= total) begin
        k = (c - 1) / p;
        if (k % N != N - 1) Continuous = 1'($urandom);
        else Continuous = (k < nPts - 1);
      end else begin
        Continuous = 1'b0;
      end
      CfgWe   = busyWrites && (c >= 1) && (c <= total) && (abortAt == 0 || c <= abortAt);
      CfgAddr = IW'($urandom);
      CfgData = $urandom;
    end
    lastPI = ePI;
    lastPM = ePM;
    idleInputs();
  endtask

  initial begin
    Rst         = 1'b1;
    DwellCycles = '0;
    CfgAddr     = '0;
    CfgData     = '0;
    idleInputs();
    setStep(16'h4000);
    resetModel();

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst_PhaseInc", 0, PhaseInc, 32'h0);
    check("rst_PhaseMod", 0, 32'(PhaseMod), 32'h0);
    check("rst_Busy", 0, 32'(Busy), 32'h0);
    check("rst_Settled", 0, 32'(Settled), 32'h0);
    check("rst_NcoUpdate", 0, 32'(NcoUpdate), 32'h0);
    check("rst_Done", 0, 32'(Done), 32'h0);
    check("rst_PointIdx", 0, 32'(PointIdx), 32'h0);
    Rst = 1'b0;
    @(negedge Clk);

    // Default table, dwell 10
    runSweep(10, N, 0, 0, 1'b0);
    // Continuous for two extra rounds, then stop at the next last point
    runSweep(int'($urandom_range(1, 6)), 3 * N, 0, 0, 1'b1);
    // Abort in SETTLE of point 2 (dwell 5 -> period 15, offset 4), with a
    // Start pulse while busy
    runSweep(5, N, 1 + 2 * 15 + 4, 7, 1'b0);
    // Host write in IDLE is used; writes while busy are dropped
    cfgWrite(2'd1, 32'h0A3D70A4);
    runSweep(3, N, 0, 0, 1'b1);
    // Zero dwell acts as one cycle; Start while busy ignored
    runSweep(0, N, 0, 13, 1'b0);

    // Abort and Start together in IDLE: stays idle
    @(negedge Clk);
    Start = 1'b1;
    Abort = 1'b1;
    @(negedge Clk);
    idleInputs();
    check("abortStart_Busy", 1, 32'(Busy), 32'h0);
    @(negedge Clk);
    check("abortStart_Busy", 2, 32'(Busy), 32'h0);
    check("abortStart_NcoUpdate", 2, 32'(NcoUpdate), 32'h0);

    // Randomized sweeps
    for (int r = 0; r < 4; r++) begin
      cfgWrite(IW'($urandom), $urandom);
      setStep(16'($urandom));
      runSweep(int'($urandom_range(0, 8)), N * int'($urandom_range(1, 2)), 0,
               int'($urandom_range(1, 40)), 1'b1);
    end

    // Reset mid-sweep is a full reset
    @(negedge Clk);
    DwellCycles = DW'(4);
    Start       = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (15) @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    check("midRst_PhaseInc", 0, PhaseInc, 32'h0);
    check("midRst_PhaseMod", 0, 32'(PhaseMod), 32'h0);
    check("midRst_Busy", 0, 32'(Busy), 32'h0);
    check("midRst_Settled", 0, 32'(Settled), 32'h0);
    check("midRst_PointIdx", 0, 32'(PointIdx), 32'h0);
    Rst = 1'b0;
    resetModel();
    setStep(16'h4000);
    @(negedge Clk);
    // Table defaults restored
    runSweep(2, N, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
